// File: rtl/datamover_engine.sv
`default_nettype none
// ============================================================================
// Module      : datamover_engine
// Description : Buffers a fixed-length load stream in a small FIFO and
//               replays it as the store stream, pulsing done at the end.
// Revision    : 1.0 - initial release
// ============================================================================
module datamover_engine #(
    parameter int BW         = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               test_mode_i,
    input  logic               enable_i,
    input  logic               clear_i,
    input  logic               start_i,
    input  logic [CNT_W-1:0]   len_i,
    input  logic [BW-1:0]      stream_in_data,
    input  logic [BW/8-1:0]    stream_in_strb,
    input  logic               stream_in_valid,
    output logic               stream_in_ready,
    output logic [BW-1:0]      stream_out_data,
    output logic [BW/8-1:0]    stream_out_strb,
    output logic               stream_out_valid,
    input  logic               stream_out_ready,
    output logic               busy_o,
    output logic               done_o,
    output logic [CNT_W-1:0]   in_cnt_o,
    output logic [CNT_W-1:0]   out_cnt_o
);

    localparam int c_sw = BW / 8;
    localparam int c_aw = $clog2(FIFO_DEPTH);
    localparam int c_ew = BW + c_sw;
    localparam logic [c_aw:0] c_depth = (c_aw + 1)'(FIFO_DEPTH);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_run   = 2'd1;
    localparam logic [1:0] c_drain = 2'd2;
    localparam logic [1:0] c_done  = 2'd3;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_in_cnt;
    logic [CNT_W-1:0] r_out_cnt;
    logic             r_done;
    logic [c_aw-1:0]  r_wptr;
    logic [c_aw-1:0]  r_rptr;
    logic [c_aw:0]    r_count;
    logic [c_ew-1:0]  r_mem [FIFO_DEPTH];

    logic             w_active;
    logic             w_full;
    logic             w_empty;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_push;
    logic             w_pop;
    logic [c_ew-1:0]  w_head;
    logic             w_unused;

    assign w_unused    = test_mode_i;
    assign w_active    = (r_state == c_run) || (r_state == c_drain);
    assign w_full      = (r_count == c_depth);
    assign w_empty     = (r_count == '0);
    // Ready looks only at registered occupancy, so a pop never frees a slot early.
    assign w_in_ready  = (r_state == c_run) && enable_i && !w_full && (r_in_cnt < r_len);
    assign w_out_valid = w_active && !w_empty;
    assign w_push      = w_in_ready && stream_in_valid;
    assign w_pop       = w_out_valid && stream_out_ready;
    assign w_head      = r_mem[r_rptr];

    assign stream_in_ready  = w_in_ready;
    assign stream_out_valid = w_out_valid;
    assign stream_out_data  = w_out_valid ? w_head[c_ew-1:c_sw] : '0;
    assign stream_out_strb  = w_out_valid ? w_head[c_sw-1:0] : '0;
    assign busy_o           = w_active;
    assign done_o           = r_done;
    assign in_cnt_o         = r_in_cnt;
    assign out_cnt_o        = r_out_cnt;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= {stream_in_data, stream_in_strb};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= c_idle;
            r_len     <= '0;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_done    <= 1'b0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
        end else if (clear_i) begin
            r_state   <= c_idle;
            r_len     <= '0;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_done    <= 1'b0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_push) begin
                r_wptr   <= r_wptr + c_aw'(1);
                r_in_cnt <= r_in_cnt + CNT_W'(1);
            end
            if (w_pop) begin
                r_rptr    <= r_rptr + c_aw'(1);
                r_out_cnt <= r_out_cnt + CNT_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (c_aw + 1)'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - (c_aw + 1)'(1);
            end

            case (r_state)
                c_idle: begin
                    if (start_i) begin
                        if (len_i != '0) begin
                            r_len     <= len_i;
                            r_in_cnt  <= '0;
                            r_out_cnt <= '0;
                            r_state   <= c_run;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                c_run: begin
                    if (w_push && ((r_in_cnt + CNT_W'(1)) == r_len)) begin
                        r_state <= c_drain;
                    end
                end
                c_drain: begin
                    if (w_pop && ((r_out_cnt + CNT_W'(1)) == r_len)) begin
                        r_state <= c_done;
                        r_done  <= 1'b1;
                    end
                end
                c_done: begin
                    r_state <= c_idle;
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_datamover_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_datamover_engine
// Description : Directed self-checking bench for datamover_engine.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_datamover_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        test_mode;
    logic        enable;
    logic        clear;
    logic        start;
    logic [15:0] len;
    logic [31:0] in_data;
    logic [3:0]  in_strb;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_strb;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic [15:0] in_cnt;
    logic [15:0] out_cnt;

    int vectors = 0;
    int errors  = 0;
    int base, src_idx, src_total, snk_idx, done_seen, cyc, first_in, first_out;
    bit rdy_rand, en_rand, start_noise, stall_pending;
    logic [31:0] held_data;
    logic [3:0]  held_strb;

    datamover_engine #(.BW(32), .FIFO_DEPTH(4), .CNT_W(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .test_mode_i(test_mode), .enable_i(enable),
        .clear_i(clear), .start_i(start), .len_i(len),
        .stream_in_data(in_data), .stream_in_strb(in_strb),
        .stream_in_valid(in_valid), .stream_in_ready(in_ready),
        .stream_out_data(out_data), .stream_out_strb(out_strb),
        .stream_out_valid(out_valid), .stream_out_ready(out_ready),
        .busy_o(busy), .done_o(done), .in_cnt_o(in_cnt), .out_cnt_o(out_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] beat_data(input int k);
        return 32'hC0DE0000 ^ (32'(k) * 32'h9E3779B1);
    endfunction

    function automatic logic [3:0] beat_strb(input int k);
        return 4'(k);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_src();
        in_valid = (src_idx < src_total);
        in_data  = beat_data(base + src_idx);
        in_strb  = beat_strb(base + src_idx);
    endtask

    task automatic new_test(input int n_beats);
        base          = base + 100000;
        src_idx       = 0;
        snk_idx       = 0;
        src_total     = n_beats;
        done_seen     = 0;
        first_in      = -1;
        first_out     = -1;
        stall_pending = 1'b0;
        drive_src();
    endtask

    // One clock: observe at negedge, apply the handshakes, drive after posedge.
    task automatic tick();
        bit in_hs, out_hs;
        @(negedge clk);
        cyc++;
        in_hs  = (in_valid === 1'b1) && (in_ready === 1'b1);
        out_hs = (out_valid === 1'b1) && (out_ready === 1'b1);
        if (stall_pending) begin
            check("held_valid", out_valid, 1'b1);
            check("held_data", out_data, held_data);
            check("held_strb", out_strb, held_strb);
        end
        stall_pending = (out_valid === 1'b1) && (out_ready !== 1'b1);
        held_data     = out_data;
        held_strb     = out_strb;
        if (in_hs && first_in < 0) first_in = cyc;
        if (out_valid === 1'b1 && first_out < 0) first_out = cyc;
        if (out_hs) begin
            check("out_data", out_data, beat_data(base + snk_idx));
            check("out_strb", out_strb, beat_strb(base + snk_idx));
            snk_idx++;
        end
        if (done === 1'b1) done_seen++;
        @(posedge clk);
        #1;
        if (in_hs) src_idx++;
        drive_src();
        if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
        if (en_rand) enable = 1'($urandom_range(0, 1));
        start = start_noise && (busy === 1'b1) && ($urandom_range(0, 15) == 0);
    endtask

    task automatic pulse_start(input logic [15:0] n);
        start = 1'b1;
        len   = n;
        tick();
        start = 1'b0;
    endtask

    task automatic run_until_done(input int bound);
        int n = 0;
        while (done_seen == 0 && n < bound) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check("done_once", done_seen, 1);
    endtask

    initial begin
        base = 0; cyc = 0;
        rdy_rand = 1'b0; en_rand = 1'b0; start_noise = 1'b0;
        rst_n = 1'b0; test_mode = 1'b0; enable = 1'b1; clear = 1'b0;
        start = 1'b0; len = '0; out_ready = 1'b1;
        new_test(0);

        // Reset state
        #12;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_strb", out_strb, 4'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_in_cnt", in_cnt, 16'd0);
        check("rst_out_cnt", out_cnt, 16'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) tick();

        // 8 beats, continuous flow
        new_test(8);
        pulse_start(16'd8);
        #1;
        check("t1_busy", busy, 1'b1);
        run_until_done(100);
        check("t1_latency", first_out - first_in, 1);
        check("t1_beats", snk_idx, 8);
        check("t1_in_cnt", in_cnt, 16'd8);
        check("t1_out_cnt", out_cnt, 16'd8);
        check("t1_busy_end", busy, 1'b0);

        // 6 beats with the sink stalled for 10 cycles
        new_test(6);
        out_ready = 1'b0;
        pulse_start(16'd6);
        repeat (9) tick();
        #1;
        check("t2_accepts", src_idx, 4);
        check("t2_in_cnt", in_cnt, 16'd4);
        check("t2_full_ready", in_ready, 1'b0);
        check("t2_out_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        run_until_done(100);
        check("t2_beats", snk_idx, 6);
        check("t2_out_cnt", out_cnt, 16'd6);

        // 3 beats while upstream offers 5
        new_test(5);
        pulse_start(16'd3);
        run_until_done(100);
        #1;
        check("t3_accepts", src_idx, 3);
        check("t3_in_cnt", in_cnt, 16'd3);
        check("t3_beats", snk_idx, 3);
        check("t3_pending_valid", in_valid, 1'b1);
        check("t3_in_ready", in_ready, 1'b0);
        src_total = 0;
        drive_src();

        // Zero-length start
        new_test(0);
        start = 1'b1;
        len   = 16'd0;
        @(negedge clk);
        check("t4_done_pre", done, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("t4_done", done, 1'b1);
        check("t4_busy", busy, 1'b0);
        check("t4_out_valid", out_valid, 1'b0);
        @(negedge clk);
        check("t4_done_post", done, 1'b0);
        check("t4_busy_post", busy, 1'b0);
        @(posedge clk); #1;

        // Clear mid-transfer with one beat buffered
        new_test(2);
        pulse_start(16'd8);
        for (int n = 0; n < 50 && src_idx < 2; n++) tick();
        clear     = 1'b1;
        out_ready = 1'b0;
        #1;
        check("t5_pre_valid", out_valid, 1'b1);
        check("t5_pre_in_cnt", in_cnt, 16'd2);
        check("t5_pre_out_cnt", out_cnt, 16'd1);
        @(posedge clk); #1;
        clear = 1'b0;
        #1;
        check("t5_out_valid", out_valid, 1'b0);
        check("t5_in_cnt", in_cnt, 16'd0);
        check("t5_out_cnt", out_cnt, 16'd0);
        check("t5_busy", busy, 1'b0);
        check("t5_in_ready", in_ready, 1'b0);
        repeat (3) tick();
        check("t5_no_done", done_seen, 0);
        new_test(2);
        out_ready = 1'b1;
        pulse_start(16'd2);
        run_until_done(100);
        check("t5_beats", snk_idx, 2);
        check("t5_final_out_cnt", out_cnt, 16'd2);

        // 1000 beats with random backpressure, enable and stray starts
        new_test(1000);
        pulse_start(16'd1000);
        rdy_rand = 1'b1; en_rand = 1'b1; start_noise = 1'b1;
        run_until_done(20000);
        rdy_rand = 1'b0; en_rand = 1'b0; start_noise = 1'b0;
        start = 1'b0; enable = 1'b1;
        check("t6_beats", snk_idx, 1000);
        check("t6_in_cnt", in_cnt, 16'd1000);
        check("t6_out_cnt", out_cnt, 16'd1000);
        check("t6_busy", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
